// File: rtl/tnn_pkg.sv
// Shared types for the temporal neural network blocks.
package tnn_pkg;

  typedef enum logic {
    TIE_PRIORITY,
    TIE_ALL
  } tie_mode_t;

  typedef enum logic {
    COLLECT,
    SATURATED
  } li_state_t;

endpackage

// File: rtl/kwta_select.sv
// Grants the lowest-index set bits of req, at most slots of them.
module kwta_select #(
  parameter int unsigned NEURONS = 8
) (
  input  logic [NEURONS-1:0]         req,
  input  logic [$clog2(NEURONS+1)-1:0] slots,
  output logic [NEURONS-1:0]         grant
);

  localparam int unsigned CW = $clog2(NEURONS + 1);

  logic [CW-1:0] taken;

  always_comb begin
    grant = '0;
    taken = '0;
    for (int i = 0; i < NEURONS; i++) begin
      if (req[i] && (taken < slots)) begin
        grant[i] = 1'b1;
        taken    = taken + 1'b1;
      end
    end
  end

endmodule

// File: rtl/kwta_inhibition.sv
// k-winner-take-all lateral inhibition over one gamma cycle of active-low spike lanes.
module kwta_inhibition
  import tnn_pkg::*;
#(
  parameter int unsigned NEURONS  = 8,
  parameter int unsigned K        = 1,
  parameter tie_mode_t   TIE_MODE = TIE_PRIORITY
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NEURONS-1:0]           in_spikes,
  input  logic                         gamma_clear,
  output logic [NEURONS-1:0]           out_spikes,
  output logic [NEURONS-1:0]           inhibited,
  output logic [$clog2(NEURONS+1)-1:0] winner_count,
  output logic                         saturated
);

  localparam int unsigned CW = $clog2(NEURONS + 1);
  localparam logic [CW-1:0] KC = CW'(K);

  function automatic logic [CW-1:0] popcount(input logic [NEURONS-1:0] v);
    logic [CW-1:0] c;
    c = '0;
    for (int i = 0; i < NEURONS; i++) c = c + CW'(v[i]);
    return c;
  endfunction

  logic [NEURONS-1:0] prev_q, prev_d;
  logic [NEURONS-1:0] win_q, win_d;
  logic [NEURONS-1:0] inh_q, inh_d;
  logic [CW-1:0]      count_q, count_d;
  li_state_t          state_q, state_d;

  logic [NEURONS-1:0] fire, grant, new_win, new_inh;
  logic [CW-1:0]      n_fire, slots;

  // Lanes already decided this gamma cycle cannot fire again.
  assign fire   = prev_q & ~in_spikes & ~win_q & ~inh_q;
  assign n_fire = popcount(fire);
  assign slots  = (count_q < KC) ? KC - count_q : '0;

  kwta_select #(
    .NEURONS(NEURONS)
  ) u_select (
    .req  (fire),
    .slots(slots),
    .grant(grant)
  );

  always_comb begin
    prev_d  = in_spikes;
    win_d   = win_q;
    inh_d   = inh_q;
    count_d = count_q;
    state_d = state_q;
    new_win = '0;
    new_inh = '0;
    if (gamma_clear) begin
      win_d   = '0;
      inh_d   = '0;
      count_d = '0;
      state_d = COLLECT;
    end else begin
      unique case (state_q)
        COLLECT: begin
          if ((n_fire <= slots) || (TIE_MODE == TIE_ALL)) new_win = fire;
          else                                            new_win = grant;
          new_inh = fire & ~new_win;
          win_d   = win_q | new_win;
          inh_d   = inh_q | new_inh;
          count_d = count_q + popcount(new_win);
          if (count_d >= KC) state_d = SATURATED;
        end
        SATURATED: begin
          inh_d = inh_q | fire;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prev_q  <= '1;
      win_q   <= '0;
      inh_q   <= '0;
      count_q <= '0;
      state_q <= COLLECT;
    end else begin
      prev_q  <= prev_d;
      win_q   <= win_d;
      inh_q   <= inh_d;
      count_q <= count_d;
      state_q <= state_d;
    end
  end

  assign out_spikes   = ~win_q;
  assign inhibited    = inh_q;
  assign winner_count = count_q;
  assign saturated    = (state_q == SATURATED);

endmodule

// File: tb/tb_kwta_inhibition.sv
// Scoreboard bench: four configurations share stimulus; expectations checked by a monitor.
module tb_kwta_inhibition;
  import tnn_pkg::*;

  logic       clk;
  logic       rst_n;
  logic [7:0] in_spikes;
  logic       gamma_clear;

  logic [3:0][7:0] o_s;
  logic [3:0][7:0] o_i;
  logic [3:0][3:0] o_c;
  logic [3:0]      o_sat;

  // 0: K=1 priority, 1: K=2 priority, 2: K=2 tie-all, 3: K=8
  kwta_inhibition #(.NEURONS(8), .K(1), .TIE_MODE(TIE_PRIORITY)) u_a (
    .clk(clk), .rst_n(rst_n), .in_spikes(in_spikes), .gamma_clear(gamma_clear),
    .out_spikes(o_s[0]), .inhibited(o_i[0]), .winner_count(o_c[0]), .saturated(o_sat[0]));
  kwta_inhibition #(.NEURONS(8), .K(2), .TIE_MODE(TIE_PRIORITY)) u_b (
    .clk(clk), .rst_n(rst_n), .in_spikes(in_spikes), .gamma_clear(gamma_clear),
    .out_spikes(o_s[1]), .inhibited(o_i[1]), .winner_count(o_c[1]), .saturated(o_sat[1]));
  kwta_inhibition #(.NEURONS(8), .K(2), .TIE_MODE(TIE_ALL)) u_c (
    .clk(clk), .rst_n(rst_n), .in_spikes(in_spikes), .gamma_clear(gamma_clear),
    .out_spikes(o_s[2]), .inhibited(o_i[2]), .winner_count(o_c[2]), .saturated(o_sat[2]));
  kwta_inhibition #(.NEURONS(8), .K(8), .TIE_MODE(TIE_PRIORITY)) u_d (
    .clk(clk), .rst_n(rst_n), .in_spikes(in_spikes), .gamma_clear(gamma_clear),
    .out_spikes(o_s[3]), .inhibited(o_i[3]), .winner_count(o_c[3]), .saturated(o_sat[3]));

  typedef struct {
    int         d;
    string      nm;
    logic [7:0] o;
    logic [7:0] inh;
    logic [3:0] c;
    logic       s;
  } exp_t;

  exp_t q[$];
  int   tests = 0;
  int   fails = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Expectations pushed before an edge are checked on the following negedge.
  always @(negedge clk) begin
    while (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      tests++;
      if (o_s[e.d] !== e.o || o_i[e.d] !== e.inh || o_c[e.d] !== e.c || o_sat[e.d] !== e.s) begin
        fails++;
        $display("FAIL %s dut%0d: got out=%h inh=%h cnt=%0d sat=%b, want out=%h inh=%h cnt=%0d sat=%b",
                 e.nm, e.d, o_s[e.d], o_i[e.d], o_c[e.d], o_sat[e.d], e.o, e.inh, e.c, e.s);
      end
    end
  end

  task automatic exp1(input int d, input string nm, input logic [7:0] o, input logic [7:0] inh,
                      input logic [3:0] c, input logic s);
    exp_t e;
    e.d = d; e.nm = nm; e.o = o; e.inh = inh; e.c = c; e.s = s;
    q.push_back(e);
  endtask

  task automatic exp_idle(input string nm);
    for (int d = 0; d < 4; d++) exp1(d, nm, 8'hFF, 8'h00, 4'd0, 1'b0);
  endtask

  task automatic drive(input logic [7:0] spk, input logic clr, input logic rn);
    in_spikes   = spk;
    gamma_clear = clr;
    rst_n       = rn;
  endtask

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  initial begin
    drive(8'hFF, 1'b0, 1'b0);
    exp_idle("reset");
    tick;
    // Quiet inputs for 8 cycles
    for (int i = 0; i < 8; i++) begin
      drive(8'hFF, 1'b0, 1'b1);
      exp1(0, "quiet", 8'hFF, 8'h00, 4'd0, 1'b0);
      tick;
    end
    exp_idle("quiet_all");
    tick;

    // Lane 0 then lanes 2,3
    drive(8'hFE, 1'b0, 1'b1);
    exp1(0, "lane0_k1", 8'hFE, 8'h00, 4'd1, 1'b1);
    exp1(1, "lane0_k2", 8'hFE, 8'h00, 4'd1, 1'b0);
    exp1(2, "lane0_all", 8'hFE, 8'h00, 4'd1, 1'b0);
    exp1(3, "lane0_k8", 8'hFE, 8'h00, 4'd1, 1'b0);
    tick;
    drive(8'hF2, 1'b0, 1'b1);
    exp1(0, "late_inhib_k1", 8'hFE, 8'h0C, 4'd1, 1'b1);
    exp1(1, "late_tie_k2", 8'hFA, 8'h08, 4'd2, 1'b1);
    exp1(2, "late_tie_all", 8'hF2, 8'h00, 4'd3, 1'b1);
    exp1(3, "late_k8", 8'hF2, 8'h00, 4'd3, 1'b0);
    tick;
    drive(8'hF2, 1'b1, 1'b1);
    exp_idle("clear");
    tick;
    drive(8'hF2, 1'b0, 1'b1);
    exp_idle("held_no_refire");
    tick;
    drive(8'hFF, 1'b0, 1'b1);
    tick;
    drive(8'hFF, 1'b1, 1'b1);
    tick;

    // Lanes 1,2,3 together
    drive(8'hF1, 1'b0, 1'b1);
    exp1(0, "tie3_k1", 8'hFD, 8'h0C, 4'd1, 1'b1);
    exp1(1, "tie3_k2_pri", 8'hF9, 8'h08, 4'd2, 1'b1);
    exp1(2, "tie3_k2_all", 8'hF1, 8'h00, 4'd3, 1'b1);
    exp1(3, "tie3_k8", 8'hF1, 8'h00, 4'd3, 1'b0);
    tick;

    // Clear coincident with a new fire, lane 0 held low
    drive(8'hFF, 1'b1, 1'b1);
    exp_idle("clear2");
    tick;
    drive(8'hFE, 1'b0, 1'b1);
    exp1(0, "lane0_again", 8'hFE, 8'h00, 4'd1, 1'b1);
    tick;
    drive(8'hDE, 1'b1, 1'b1);
    exp_idle("clear_wins");
    tick;
    drive(8'hDE, 1'b0, 1'b1);
    exp_idle("after_clear_quiet");
    tick;

    // Reset mid-cycle with lane 4 held low
    drive(8'hFF, 1'b1, 1'b1);
    tick;
    drive(8'hEF, 1'b0, 1'b1);
    exp1(0, "lane4_win", 8'hEF, 8'h00, 4'd1, 1'b1);
    tick;
    drive(8'hEF, 1'b0, 1'b0);
    exp_idle("mid_reset");
    tick;
    drive(8'hEF, 1'b0, 1'b1);
    exp1(0, "lane4_rewin", 8'hEF, 8'h00, 4'd1, 1'b1);
    exp1(3, "lane4_rewin_k8", 8'hEF, 8'h00, 4'd1, 1'b0);
    tick;
    drive(8'hEF, 1'b0, 1'b1);
    exp1(0, "lane4_sticky", 8'hEF, 8'h00, 4'd1, 1'b1);
    tick;

    // Every remaining lane fires at once
    drive(8'h00, 1'b0, 1'b1);
    exp1(0, "all_k1", 8'hEF, 8'hEF, 4'd1, 1'b1);
    exp1(1, "all_k2", 8'hEE, 8'hEE, 4'd2, 1'b1);
    exp1(2, "all_tie", 8'h00, 8'h00, 4'd8, 1'b1);
    exp1(3, "all_k8", 8'h00, 8'h00, 4'd8, 1'b1);
    tick;
    drive(8'hFF, 1'b0, 1'b1);
    exp1(3, "k8_sticky", 8'h00, 8'h00, 4'd8, 1'b1);
    tick;

    if (q.size() != 0) begin
      fails++;
      $display("FAIL drain: got %0d pending expectations, want 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
